// File: rtl/reg_access_pkg.sv
// Shared definitions for the register-access sequencer: MIPS opcodes,
// FSM state encoding and immediate-extension modes.
package reg_access_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_WB
  } state_t;

  typedef enum logic [1:0] {
    SEXT,
    ZEXT,
    LUI
  } ext_mode_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational MIPS field decode: source registers, destination,
// write-back flag and extended immediate.
module instr_decode
  import reg_access_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [31:0]   instr,
  output logic [AW-1:0] rs,
  output logic [AW-1:0] rt,
  output logic [AW-1:0] dest,
  output logic          writes,
  output logic [DW-1:0] op_imm
);

  logic [5:0]  opcode;
  logic [15:0] imm;
  ext_mode_t   mode;

  always_comb begin
    opcode = instr[31:26];
    imm    = instr[15:0];
    rs     = AW'(instr[25:21]);
    rt     = AW'(instr[20:16]);
    dest   = AW'(instr[20:16]);
    writes = 1'b0;
    mode   = SEXT;

    case (opcode)
      OP_RTYPE: begin
        dest   = AW'(instr[15:11]);
        writes = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: writes = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI: begin
        writes = 1'b1;
        mode   = ZEXT;
      end
      OP_LUI: begin
        writes = 1'b1;
        mode   = LUI;
      end
      OP_JAL: begin
        dest   = AW'(REG_RA);
        writes = 1'b1;
      end
      default: writes = 1'b0;
    endcase

    case (mode)
      ZEXT:    op_imm = DW'(imm);
      LUI:     op_imm = DW'({imm, 16'h0000});
      default: op_imm = DW'($signed(imm));
    endcase
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Single-issue RF access sequencer: latch, read operands, hand off to
// execute, wait for the result and write it back once.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   ST_IDLE     | ready for an instruction, latches IR on accept
//   ST_READ     | RF addresses driven, operands/decode captured
//   ST_ISSUE    | op_valid high until execute takes the operands
//   ST_WAIT_RES | waiting for res_valid, captures write data
//   ST_WB       | single write-back cycle, retired count bumps
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [AW-1:0]    rf_raddr1,
  output logic [AW-1:0]    rf_raddr2,
  input  logic [DW-1:0]    rf_rdata1,
  input  logic [DW-1:0]    rf_rdata2,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  output logic [DW-1:0]    op_imm,
  output logic [11:0]      op_ctrl,
  input  logic             res_valid,
  input  logic [DW-1:0]    res_data,
  output logic [CNT_W-1:0] retired
);

  state_t        state, state_nx;
  logic [31:0]   ir;
  logic [AW-1:0] dest_q;
  logic          writes_q;

  logic [AW-1:0] dec_rs, dec_rt, dec_dest;
  logic          dec_writes;
  logic [DW-1:0] dec_imm;

  instr_decode #(.DW(DW), .AW(AW)) u_decode (
    .instr  (ir),
    .rs     (dec_rs),
    .rt     (dec_rt),
    .dest   (dec_dest),
    .writes (dec_writes),
    .op_imm (dec_imm)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir       <= '0;
      dest_q   <= '0;
      writes_q <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_imm   <= '0;
      op_ctrl  <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      retired  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (instr_valid) ir <= instr;
        ST_READ: begin
          op_a     <= rf_rdata1;
          op_b     <= rf_rdata2;
          op_imm   <= dec_imm;
          op_ctrl  <= {ir[31:26], ir[5:0]};
          dest_q   <= dec_dest;
          writes_q <= dec_writes;
        end
        ST_WAIT_RES: if (res_valid) begin
          rf_wdata <= res_data;
          rf_waddr <= dest_q;
        end
        ST_WB:   retired <= retired + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    op_valid    = 1'b0;
    rf_we       = 1'b0;
    rf_raddr1   = '0;
    rf_raddr2   = '0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = ST_READ;
      end
      ST_READ: begin
        rf_raddr1 = dec_rs;
        rf_raddr2 = dec_rt;
        state_nx  = ST_ISSUE;
      end
      ST_ISSUE: begin
        rf_raddr1 = dec_rs;
        rf_raddr2 = dec_rt;
        op_valid  = 1'b1;
        if (op_ready) state_nx = ST_WAIT_RES;
      end
      ST_WAIT_RES: if (res_valid) state_nx = ST_WB;
      ST_WB: begin
        // Writes to $0 are suppressed so the RF never sees them.
        rf_we    = writes_q && (dest_q != '0);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
